accel_sched: RTL

Sequencer and round-robin arbiter for the tile's shared accelerator. It sits between up to `REQ_NUM` requesters (core-side SFR ports, DMA agents) and the accelerator's `sw_on`/`start`/`rdy`/`int_fin` control pins. It handles:
- power-up of the accelerator,
- granting one job at a time,
- issuing the start pulse,
- completion or timeout reporting back to the owning requester.

---
 rtl/accel_sched_if.sv | 30 +++
 rtl/accel_sched.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/accel_sched_if.sv
// Control bundle between requesters/accelerator pins and accel_sched.
// Driven by the requester/accelerator side (master) and consumed by the scheduler (slave).
interface accel_sched_if #(
  parameter int REQ_NUM   = 4,
  parameter int TIMEOUT_W = 16
);
  localparam int OW = $clog2(REQ_NUM);

  logic [REQ_NUM-1:0]   req_i;
  logic [TIMEOUT_W-1:0] timeout_i;
  logic                 accel_rdy_i;
  logic                 accel_int_fin_i;
  logic [REQ_NUM-1:0]   grant_o;
  logic [REQ_NUM-1:0]   done_o;
  logic [REQ_NUM-1:0]   err_o;
  logic [OW-1:0]        owner_bo;
  logic                 busy_o;
  logic                 accel_sw_on_o;
  logic                 accel_start_o;

  modport master (
    output req_i, timeout_i, accel_rdy_i, accel_int_fin_i,
    input  grant_o, done_o, err_o, owner_bo, busy_o, accel_sw_on_o, accel_start_o
  );

  modport slave (
    input  req_i, timeout_i, accel_rdy_i, accel_int_fin_i,
    output grant_o, done_o, err_o, owner_bo, busy_o, accel_sw_on_o, accel_start_o
  );
endinterface

// File: rtl/accel_sched.sv
// Power sequencer + round-robin job arbiter for the shared accelerator; grant/start 1 cycle after an IDLE request, all outputs registered.
// Requesters hold req until granted (no other backpressure); ACCEL_AUTO_PWROFF_EN adds idle auto power-off.
module accel_sched #(
  parameter int REQ_NUM     = 4,
  parameter int TIMEOUT_W   = 16,
  parameter int PWROFF_IDLE = 64
) (
  input logic          clk_i,
  input logic          rst_ni,
  accel_sched_if.slave bus
);
  localparam int OW = $clog2(REQ_NUM);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWRUP,
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [REQ_NUM-1:0]   grant_q, grant_d;
  logic [REQ_NUM-1:0]   done_q, done_d;
  logic [REQ_NUM-1:0]   err_q, err_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 sw_on_q, sw_on_d;
  logic                 start_q, start_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W:0]   cnt_inc;
  logic                 expired;
  logic [OW-1:0]        pick;
  logic                 pick_vld;

`ifdef ACCEL_AUTO_PWROFF_EN
  localparam int IW = $clog2(PWROFF_IDLE + 1);
  logic [IW-1:0] idle_q, idle_d;
`else
  logic unused_pwroff;
  assign unused_pwroff = ^PWROFF_IDLE;
`endif

  // Round-robin: indices above last owner first, then wrap to the low end.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!pick_vld && bus.req_i[i] && (OW'(i) > last_q)) begin
        pick     = OW'(i);
        pick_vld = 1'b1;
      end
    end
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!pick_vld && bus.req_i[i] && (OW'(i) <= last_q)) begin
        pick     = OW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  // Extra bit keeps a saturated counter from ever matching timeout_i.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;
  assign expired = (bus.timeout_i != '0) && (cnt_inc == {1'b0, bus.timeout_i});

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
`ifdef ACCEL_AUTO_PWROFF_EN
    idle_d  = '0;
`endif
    case (state_q)
      S_OFF: begin
        if (|bus.req_i) state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (bus.accel_rdy_i) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          grant_d = {{(REQ_NUM-1){1'b0}}, 1'b1} << pick;
          start_d = 1'b1;
          state_d = S_START;
        end
`ifdef ACCEL_AUTO_PWROFF_EN
        else if (idle_q == IW'(PWROFF_IDLE - 1)) begin
          state_d = S_OFF;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_inc[TIMEOUT_W-1:0];
        // Completion takes precedence over a same-cycle expiry.
        if (bus.accel_int_fin_i) begin
          done_d[owner_q] = 1'b1;
          last_d          = owner_q;
          state_d         = S_IDLE;
        end else if (expired) begin
          err_d[owner_q] = 1'b1;
          last_d         = owner_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_OFF;
    endcase
    busy_d  = (state_d == S_START) || (state_d == S_RUN);
    sw_on_d = (state_d != S_OFF);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_OFF;
      owner_q <= '0;
      last_q  <= OW'(REQ_NUM - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      sw_on_q <= 1'b0;
      start_q <= 1'b0;
`ifdef ACCEL_AUTO_PWROFF_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      sw_on_q <= sw_on_d;
      start_q <= start_d;
`ifdef ACCEL_AUTO_PWROFF_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign bus.grant_o       = grant_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.owner_bo      = owner_q;
  assign bus.busy_o        = busy_q;
  assign bus.accel_sw_on_o = sw_on_q;
  assign bus.accel_start_o = start_q;
endmodule
